bcd_scan_ctrl: RTL and testbench
================================

Name: bcd_scan_ctrl

Overview:
- Sequencing controller for a three-digit seven-segment display on the FPGA board.
- Accepts an 8-bit binary value over a valid/ready handshake.
- Converts it to hundreds/tens/ones BCD with a multi-cycle shift-add-3 (double-dabble) engine, one bit per clock.
- Time-multiplexes the three digits onto one shared active-low segment bus with per-digit active-low anode enables.

Parameters:
- REFRESH_DIV, default 50000: clock cycles each digit stays lit before the scanner advances. Legal range is 1 to 2^20-1; a value of 1 advances every cycle.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- load_valid  input  1  load_data is valid this cycle
- load_data  input  8  unsigned binary value to display, 0..255
- load_ready  output  1  controller can accept a value (high only in IDLE)
- busy  output  1  conversion in progress (CONVERT or LATCH)
- seg  output  7  active-low segments, bit6=g .. bit0=a
- an  output  3  active-low digit enables: an[0]=ones, an[1]=tens, an[2]=hundreds

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values:
  - FSM=IDLE, load_ready=1, busy=0.
  - Shift register, BCD work registers and display registers = 0.
  - Prescaler=0, digit index=ones, an=3'b110, seg=7'b1000000.
- FSM states: IDLE, CONVERT, LATCH.
- IDLE:
  - load_ready=1.
  - When load_valid&&load_ready: capture load_data into shift register, clear BCD work registers (h,t,o), bit counter=7, go to CONVERT.
  - No load_valid: stay in IDLE.
- CONVERT, one step per cycle:
  - Each of h, t, o that is >=5 gets +3 (4-bit wrap impossible by construction).
  - Then shift {h,t,o,shift_reg} left by 1, MSB of data first.
  - The counter decrements. After the step with counter==0 (8 cycles total), go to LATCH.
  - load_valid is ignored; load_ready=0.
- LATCH: copy h,t,o into display registers in one cycle, then go to IDLE.
- Latency:
  - Accept edge = cycle 0. Display registers update on the edge ending cycle 9.
  - load_ready is high again in cycle 10.
  - Throughput: one value per 10 cycles.
- Display registers hold the previous value throughout a conversion. No partial results are ever shown.
- Scanner (independent of the FSM, runs continuously):
  - Prescaler counts 0..REFRESH_DIV-1.
  - On terminal count: prescaler wraps to 0 and the digit index advances ones -> tens -> hundreds -> ones.
  - an is the one-hot active-low decode of the digit index; exactly one bit is low at all times.
  - seg is the decode of the selected display register.
  - Both an and seg derive only from registers, so no combinational path exists from load_data to outputs.
- Segment decode (active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
  - Any other nibble = 1111111 (blank).
- Simultaneous events: a LATCH update coincident with a scanner advance is legal. The newly selected digit shows the new value in that same cycle.
- Reset mid-conversion: immediate abort to the reset state; display shows 0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Hundreds digit is blanked (seg=1111111 while selected) when hundreds==0.
  - Tens digit is blanked when hundreds==0 and tens==0.
  - Ones digit is never blanked.
  - an scanning is unchanged.
- Undefined: all three digits are always displayed, including leading zeros.

Test Plan (REFRESH_DIV=4 for all scenarios):
- Load 255 in IDLE: busy high for 9 cycles, load_ready returns in cycle 10. Scan shows an=110/seg=0010010, an=101/seg=0010010, an=011/seg=0100100, each for 4 cycles.
- Load 100 then 7, with macro defined:
  - 100 shows hundreds 1111001, tens 1000000, ones 1000000.
  - 7 shows hundreds and tens 1111111, ones 1111000.
- Load 0 without macro: all digits 1000000. With macro: hundreds/tens 1111111, ones 1000000.
- Hold load_valid high continuously with data 42 then 199: only accepted when load_ready=1, 10 cycles apart. The display never shows an intermediate BCD value.
- Assert rst at CONVERT cycle 4 while loading 128: outputs asynchronously reach the reset values (an=110, seg=1000000, load_ready=1). A subsequent load of 128 displays 1,2,8.
- Check prescaler wrap and one-hot an over 30 cycles with no load: an sequence 110, 101, 011, 110 repeats every 12 cycles.

Source files
------------

// File: rtl/bcd_scan_if.sv
// Handshake and display bus of the BCD scan controller.
// The master drives a value to show; the slave (controller) reports
// readiness and busy status and drives the multiplexed display lines.
interface bcd_scan_if;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       busy;
  logic [6:0] seg;
  logic [2:0] an;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  busy,
    input  seg,
    input  an
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output busy,
    output seg,
    output an
  );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// Three-digit seven-segment display controller.
// Accepts an 8-bit binary value, converts it to BCD with a one-bit-per-clock
// shift-add-3 engine, and time-multiplexes hundreds/tens/ones onto a shared
// active-low segment bus with active-low anode enables.
// Optional build macro LEADING_ZERO_BLANK_EN: blanks a zero hundreds digit,
// and a zero tens digit when hundreds is also zero. Ones is always shown.
module bcd_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  bcd_scan_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_LATCH   = 2'd2
  } state_t;

  localparam logic [19:0] PRESC_TC = 20'(REFRESH_DIV - 1);

  // Digit index encoding; scan order is ones -> tens -> hundreds
  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  h_q, h_d, t_q, t_d, o_q, o_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  dsp_h_q, dsp_h_d, dsp_t_q, dsp_t_d, dsp_o_q, dsp_o_d;
  logic [19:0] presc_q, presc_d;
  logic [1:0]  dig_q, dig_d;

  logic        load_ready;
  logic        busy;
  logic [19:0] dd_step;
  logic [3:0]  sel_digit;
  logic        sel_blank;
  logic [2:0]  an;
  logic [6:0]  seg;

  // Double-dabble correction: a BCD nibble >= 5 would overflow past 9 when
  // doubled, so pre-add 3. Inputs never exceed 9, so the sum fits in 4 bits.
  function automatic logic [3:0] add3(input logic [3:0] v);
    return (v >= 4'd5) ? (v + 4'd3) : v;
  endfunction

  // Active-low seven-segment decode, bit6=g .. bit0=a; non-decimal = blank
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0011000;
      default: return 7'b1111111;
    endcase
  endfunction

  // One conversion step: correct each BCD nibble, then shift the whole
  // {h,t,o,data} chain left so the next data MSB enters the ones digit.
  assign dd_step = {add3(h_q), add3(t_q), add3(o_q), shift_q} << 1;

  // Control FSM next-state and conversion datapath
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    h_d        = h_q;
    t_d        = t_q;
    o_d        = o_q;
    cnt_d      = cnt_q;
    dsp_h_d    = dsp_h_q;
    dsp_t_d    = dsp_t_q;
    dsp_o_d    = dsp_o_q;
    load_ready = 1'b0;
    busy       = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_ready = 1'b1;
        if (bus.load_valid) begin
          shift_d = bus.load_data;
          h_d     = 4'd0;
          t_d     = 4'd0;
          o_d     = 4'd0;
          cnt_d   = 3'd7;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        busy                     = 1'b1;
        {h_d, t_d, o_d, shift_d} = dd_step;
        cnt_d                    = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        // Display registers change only here, so partial results never show
        busy    = 1'b1;
        dsp_h_d = h_q;
        dsp_t_d = t_q;
        dsp_o_d = o_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM, conversion and display registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= 8'd0;
      h_q     <= 4'd0;
      t_q     <= 4'd0;
      o_q     <= 4'd0;
      cnt_q   <= 3'd0;
      dsp_h_q <= 4'd0;
      dsp_t_q <= 4'd0;
      dsp_o_q <= 4'd0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      h_q     <= h_d;
      t_q     <= t_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
      dsp_h_q <= dsp_h_d;
      dsp_t_q <= dsp_t_d;
      dsp_o_q <= dsp_o_d;
    end
  end

  // Free-running refresh prescaler and digit index advance
  always_comb begin
    presc_d = presc_q + 20'd1;
    dig_d   = dig_q;
    if (presc_q >= PRESC_TC) begin
      presc_d = 20'd0;
      dig_d   = (dig_q == DIG_HUND) ? DIG_ONES : (dig_q + 2'd1);
    end
  end

  // Scanner registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= 20'd0;
      dig_q   <= DIG_ONES;
    end else begin
      presc_q <= presc_d;
      dig_q   <= dig_d;
    end
  end

  // Anode select and segment drive, derived from registers only
  always_comb begin
    an        = 3'b110;
    sel_digit = dsp_o_q;
    sel_blank = 1'b0;
    case (dig_q)
      DIG_TENS: begin
        an        = 3'b101;
        sel_digit = dsp_t_q;
`ifdef LEADING_ZERO_BLANK_EN
        sel_blank = (dsp_h_q == 4'd0) && (dsp_t_q == 4'd0);
`else
        sel_blank = 1'b0;
`endif
      end
      DIG_HUND: begin
        an        = 3'b011;
        sel_digit = dsp_h_q;
`ifdef LEADING_ZERO_BLANK_EN
        sel_blank = (dsp_h_q == 4'd0);
`else
        sel_blank = 1'b0;
`endif
      end
      default: begin
        an        = 3'b110;
        sel_digit = dsp_o_q;
        sel_blank = 1'b0;
      end
    endcase
    seg = sel_blank ? 7'b1111111 : seg_decode(sel_digit);
  end

  assign bus.load_ready = load_ready;
  assign bus.busy       = busy;
  assign bus.an         = an;
  assign bus.seg        = seg;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed testbench for bcd_scan_ctrl with REFRESH_DIV=4.
// Expected segment patterns are hand-written constants; the leading-zero
// expectation follows the LEADING_ZERO_BLANK_EN build macro.
module tb_bcd_scan_ctrl;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0011000;
  localparam logic [6:0] BL = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = BL;
`else
  localparam logic [6:0] LZ = S0;
`endif

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  bcd_scan_if bus ();

  bcd_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Compare seg with the expected pattern of whichever digit is enabled now
  task automatic seg_now(input string tag, input logic [6:0] eh, input logic [6:0] et,
                         input logic [6:0] eo);
    logic [6:0] e;
    chk({tag, "_an_onehot"}, 8'($countones(~bus.an)), 8'd1);
    case (bus.an)
      3'b110:  e = eo;
      3'b101:  e = et;
      3'b011:  e = eh;
      default: e = 7'bxxxxxxx;
    endcase
    chk({tag, "_seg"}, {1'b0, bus.seg}, {1'b0, e});
  endtask

  // Watch one full scan period (3 digits x 4 cycles)
  task automatic disp_check(input string tag, input logic [6:0] eh, input logic [6:0] et,
                            input logic [6:0] eo);
    for (int i = 0; i < 12; i++) begin
      seg_now(tag, eh, et, eo);
      @(negedge clk);
    end
  endtask

  // Load a value and check busy/load_ready over the 10-cycle transaction;
  // returns at the negedge of cycle 10 (back in IDLE, new value displayed)
  task automatic do_load(input string tag, input logic [7:0] val);
    chk({tag, "_ready_c0"}, {7'd0, bus.load_ready}, 8'd1);
    bus.load_valid = 1'b1;
    bus.load_data  = val;
    @(negedge clk);
    bus.load_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk({tag, "_busy"}, {7'd0, bus.busy}, 8'd1);
      chk({tag, "_ready_low"}, {7'd0, bus.load_ready}, 8'd0);
      @(negedge clk);
    end
    chk({tag, "_busy_c10"}, {7'd0, bus.busy}, 8'd0);
    chk({tag, "_ready_c10"}, {7'd0, bus.load_ready}, 8'd1);
  endtask

  initial begin
    logic [2:0] exp_an;
    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'd0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_an", {5'd0, bus.an}, {5'd0, 3'b110});
    chk("rst_seg", {1'b0, bus.seg}, {1'b0, S0});
    chk("rst_ready", {7'd0, bus.load_ready}, 8'd1);
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    rst = 1'b0;

    // Scan sequence: 4 cycles per digit, ones -> tens -> hundreds
    for (int k = 0; k < 30; k++) begin
      case ((k / 4) % 3)
        0:       exp_an = 3'b110;
        1:       exp_an = 3'b101;
        default: exp_an = 3'b011;
      endcase
      chk("scan_an", {5'd0, bus.an}, {5'd0, exp_an});
      chk("scan_seg", {1'b0, bus.seg}, {1'b0, S0});
      @(negedge clk);
    end

    // 255 -> 2,5,5
    do_load("l255", 8'd255);
    disp_check("d255", S2, S5, S5);

    // 100 -> 1,0,0 (no leading zeros to blank)
    do_load("l100", 8'd100);
    disp_check("d100", S1, S0, S0);

    // 7 -> 0,0,7
    do_load("l7", 8'd7);
    disp_check("d7", LZ, LZ, S7);

    // 0 -> 0,0,0
    do_load("l0", 8'd0);
    disp_check("d0", LZ, LZ, S0);

    // load_valid held high: 42 accepted now, 199 exactly 10 cycles later
    chk("hold_ready_c0", {7'd0, bus.load_ready}, 8'd1);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'd42;
    @(negedge clk);
    bus.load_data = 8'd199;
    for (int c = 1; c <= 9; c++) begin
      chk("hold_ready_a", {7'd0, bus.load_ready}, 8'd0);
      seg_now("hold_old0", LZ, LZ, S0);
      @(negedge clk);
    end
    chk("hold_ready_c10", {7'd0, bus.load_ready}, 8'd1);
    seg_now("hold_42a", LZ, S4, S2);
    @(negedge clk);
    bus.load_valid = 1'b0;
    for (int c = 11; c <= 19; c++) begin
      chk("hold_ready_b", {7'd0, bus.load_ready}, 8'd0);
      seg_now("hold_42b", LZ, S4, S2);
      @(negedge clk);
    end
    chk("hold_ready_c20", {7'd0, bus.load_ready}, 8'd1);
    disp_check("d199", S1, S9, S9);

    // Reset during conversion of 128 (CONVERT cycle 4)
    bus.load_valid = 1'b1;
    bus.load_data  = 8'd128;
    @(negedge clk);
    bus.load_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", {7'd0, bus.busy}, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_an", {5'd0, bus.an}, {5'd0, 3'b110});
    chk("mid_rst_seg", {1'b0, bus.seg}, {1'b0, S0});
    chk("mid_rst_ready", {7'd0, bus.load_ready}, 8'd1);
    chk("mid_rst_busy", {7'd0, bus.busy}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    do_load("l128", 8'd128);
    disp_check("d128", S1, S2, S8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
